demux_l1: RTL and testbench
===========================

DEMUX_L1 -- requirements
Module: demux_l1

Interface
REQ-001 Parameter: LANE_W, default 8, data width of every input and output lane.
REQ-002 Port: clk_2f  input  1  single clock, rising edge; the only clock in the block.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk_2f.
REQ-004 Port: Entrada0  input  LANE_W  lane A data, one word per clk_2f cycle.
REQ-005 Port: validEntrada0  input  1  qualifies Entrada0 in the same cycle.
REQ-006 Port: Entrada1  input  LANE_W  lane B data, one word per clk_2f cycle.
REQ-007 Port: validEntrada1  input  1  qualifies Entrada1 in the same cycle.
REQ-008 Port: Salida0 / Salida1  output  LANE_W each  even/odd words split from lane A.
REQ-009 Port: Salida2 / Salida3  output  LANE_W each  even/odd words split from lane B.
REQ-010 Port: validsalida0..3  output  1 each  qualify Salida0..3 respectively.

Function
REQ-011 The block SHALL be the receive-side inverse of the 4-to-2 lane mux: each input lane is split 1-to-2 at half rate, giving 4 output lanes.
REQ-012 A 1-bit phase register SHALL alternate EVEN(0) -> ODD(1) -> EVEN on every clk_2f edge when not in reset.
REQ-013 In EVEN, each lane SHALL capture its input word and valid into a holding register (hold_d, hold_v).
REQ-014 In ODD, the edge ending the cycle SHALL update the even output from the hold register and the odd output from the current input word and valid.
REQ-015 Latency: an EVEN word SHALL appear 2 clk_2f cycles after sampling; an ODD word SHALL appear 1 cycle after sampling; both words of a pair SHALL update on the same edge.
REQ-016 Outputs SHALL hold their values for exactly 2 clk_2f cycles between updates.
REQ-017 When an output's valid is 0, its data SHALL retain the last value that was valid.
REQ-018 An output's valid SHALL be 0 when its source valid was 0.
REQ-019 Lanes A and B SHALL share the phase register and SHALL be fully independent otherwise.
REQ-020 Data SHALL pass unmodified; there is no arithmetic and no width change.

Reset
REQ-021 While reset=1 at an edge: phase, hold_d, hold_v, Salida0..3 and validsalida0..3 SHALL all become 0.
REQ-022 The first edge with reset=0 SHALL be treated as EVEN.
REQ-023 Reset asserted mid-pair SHALL discard the held word, and no partial pair SHALL be emitted.

Configuration
REQ-024 Macro DEMUX_L1_ALIGN_EN:
- Defined: phase SHALL be held at EVEN while validEntrada0=0 and validEntrada1=0, so the first valid word after idle always maps to Salida0/Salida2.
- Undefined: phase SHALL run free per REQ-012.

Structure
REQ-025 Shared package demux_pkg SHALL hold LANE_W, PHASE_EVEN=1'b0 and PHASE_ODD=1'b1.
REQ-026 Sub-module demux1x2 SHALL implement one lane (hold register plus even/odd output registers).
- It SHALL take the phase as an input.
- demux_l1 SHALL instantiate it twice and own the phase register.

Verification
REQ-027 Reset held 3 cycles, then released with no valids -> all outputs 0 and all valids 0 throughout.
REQ-028 Lane A valid sequence 0xA1, 0xA2, 0xA3, 0xA4 starting in EVEN:
- Cycle +2: Salida0=0xA1, Salida1=0xA2, both valid.
- Cycle +4: Salida0=0xA3, Salida1=0xA4.
REQ-029 Both lanes streaming (A: 0x10, 0x11; B: 0x20, 0x21) -> Salida0..3 = 0x10, 0x11, 0x20, 0x21, updated on the same edge.
REQ-030 Lane B: 0x55 valid, then a word with validEntrada1=0 -> Salida2=0x55 valid, validsalida3=0, Salida3 keeps its prior value.
REQ-031 Reset pulsed in ODD after 0xC3 was captured in EVEN -> 0xC3 never appears, and the outputs are 0 on the following edge.
REQ-032 Alignment, first valid word 0x7E arriving in an ODD cycle after idle:
- With DEMUX_L1_ALIGN_EN: 0x7E appears on Salida0.
- Without it: 0x7E appears on Salida1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared lane width and phase encoding for the 1-to-2 lane demux.
// Combinational helpers only; no latency, no backpressure.
package demux_pkg;

  localparam int LANE_W = 8;

  typedef enum logic {
    PHASE_EVEN = 1'b0,
    PHASE_ODD  = 1'b1
  } phase_e;

  function automatic phase_e phase_flip(input phase_e p);
    return (p == PHASE_EVEN) ? PHASE_ODD : PHASE_EVEN;
  endfunction

endpackage

// File: rtl/demux1x2.sv
// One lane split 1-to-2: EVEN word parked in a hold register, pair emitted on the ODD edge.
// Even word 2 cycles, odd word 1 cycle; no backpressure, outputs hold 2 cycles.
module demux1x2
  import demux_pkg::*;
#(
  parameter int DAT_W = LANE_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  phase_e           phase_i,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             vld_i,
  output logic [DAT_W-1:0] even_dat_o,
  output logic             even_vld_o,
  output logic [DAT_W-1:0] odd_dat_o,
  output logic             odd_vld_o
);

  logic [DAT_W-1:0] hold_d_q, hold_d_d;
  logic             hold_v_q, hold_v_d;
  logic [DAT_W-1:0] even_dat_q, even_dat_d;
  logic             even_vld_q, even_vld_d;
  logic [DAT_W-1:0] odd_dat_q, odd_dat_d;
  logic             odd_vld_q, odd_vld_d;

  always_comb begin
    hold_d_d   = hold_d_q;
    hold_v_d   = hold_v_q;
    even_dat_d = even_dat_q;
    even_vld_d = even_vld_q;
    odd_dat_d  = odd_dat_q;
    odd_vld_d  = odd_vld_q;
    if (phase_i == PHASE_EVEN) begin
      hold_d_d = dat_i;
      hold_v_d = vld_i;
    end else begin
      // Data only moves with a valid word so an idle slot keeps the last good value.
      even_vld_d = hold_v_q;
      if (hold_v_q) even_dat_d = hold_d_q;
      odd_vld_d = vld_i;
      if (vld_i) odd_dat_d = dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_d_q   <= '0;
      hold_v_q   <= 1'b0;
      even_dat_q <= '0;
      even_vld_q <= 1'b0;
      odd_dat_q  <= '0;
      odd_vld_q  <= 1'b0;
    end else begin
      hold_d_q   <= hold_d_d;
      hold_v_q   <= hold_v_d;
      even_dat_q <= even_dat_d;
      even_vld_q <= even_vld_d;
      odd_dat_q  <= odd_dat_d;
      odd_vld_q  <= odd_vld_d;
    end
  end

  assign even_dat_o = even_dat_q;
  assign even_vld_o = even_vld_q;
  assign odd_dat_o  = odd_dat_q;
  assign odd_vld_o  = odd_vld_q;

endmodule

// File: rtl/demux_l1.sv
// Two-lane receive demux to four half-rate lanes sharing one phase bit; even words 2 cycles, odd 1 cycle, no backpressure.
// DEMUX_L1_ALIGN_EN parks the phase at EVEN while both lanes are idle.
module demux_l1 #(
  parameter int LANE_W = demux_pkg::LANE_W
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [LANE_W-1:0] Entrada0,
  input  logic              validEntrada0,
  input  logic [LANE_W-1:0] Entrada1,
  input  logic              validEntrada1,
  output logic [LANE_W-1:0] Salida0,
  output logic [LANE_W-1:0] Salida1,
  output logic [LANE_W-1:0] Salida2,
  output logic [LANE_W-1:0] Salida3,
  output logic              validsalida0,
  output logic              validsalida1,
  output logic              validsalida2,
  output logic              validsalida3
);

  import demux_pkg::*;

  phase_e phase_q, phase_d;

  always_comb begin
    phase_d = phase_flip(phase_q);
`ifdef DEMUX_L1_ALIGN_EN
    // Stay EVEN across idle so the first word after a gap always lands on the even output.
    if (phase_q == PHASE_EVEN && !validEntrada0 && !validEntrada1) phase_d = PHASE_EVEN;
`endif
  end

  always_ff @(posedge clk_2f) begin
    if (reset) phase_q <= PHASE_EVEN;
    else       phase_q <= phase_d;
  end

  demux1x2 #(.DAT_W(LANE_W)) u_lane_a (
    .clk_i      (clk_2f),
    .rst_i      (reset),
    .phase_i    (phase_q),
    .dat_i      (Entrada0),
    .vld_i      (validEntrada0),
    .even_dat_o (Salida0),
    .even_vld_o (validsalida0),
    .odd_dat_o  (Salida1),
    .odd_vld_o  (validsalida1)
  );

  demux1x2 #(.DAT_W(LANE_W)) u_lane_b (
    .clk_i      (clk_2f),
    .rst_i      (reset),
    .phase_i    (phase_q),
    .dat_i      (Entrada1),
    .vld_i      (validEntrada1),
    .even_dat_o (Salida2),
    .even_vld_o (validsalida2),
    .odd_dat_o  (Salida3),
    .odd_vld_o  (validsalida3)
  );

endmodule

// File: tb/tb_demux_l1.sv
// Directed stimulus for demux_l1; expected output snapshots are queued per cycle and checked by a negedge monitor.
module tb_demux_l1;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic [7:0] Entrada0, Entrada1;
  logic       validEntrada0, validEntrada1;
  logic [7:0] Salida0, Salida1, Salida2, Salida3;
  logic       validsalida0, validsalida1, validsalida2, validsalida3;

  demux_l1 #(.LANE_W(8)) dut (
    .clk_2f        (clk_2f),
    .reset         (reset),
    .Entrada0      (Entrada0),
    .validEntrada0 (validEntrada0),
    .Entrada1      (Entrada1),
    .validEntrada1 (validEntrada1),
    .Salida0       (Salida0),
    .Salida1       (Salida1),
    .Salida2       (Salida2),
    .Salida3       (Salida3),
    .validsalida0  (validsalida0),
    .validsalida1  (validsalida1),
    .validsalida2  (validsalida2),
    .validsalida3  (validsalida3)
  );

  always #5 clk_2f = ~clk_2f;

  typedef struct {
    int         due;
    logic [7:0] d0, d1, d2, d3;
    logic       v0, v1, v2, v3;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_2f) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] req, input int c);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%02h expected 0x%02h", name, c, act, req);
    end
  endfunction

  // Monitor: compare every queued snapshot that falls due this cycle.
  always @(negedge clk_2f) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.due < cyc) begin
        checks++;
        errors++;
        $display("FAIL late_entry due %0d seen at cycle %0d", mon_e.due, cyc);
      end else begin
        chk("Salida0", Salida0, mon_e.d0, cyc);
        chk("Salida1", Salida1, mon_e.d1, cyc);
        chk("Salida2", Salida2, mon_e.d2, cyc);
        chk("Salida3", Salida3, mon_e.d3, cyc);
        chk("validsalida0", {7'd0, validsalida0}, {7'd0, mon_e.v0}, cyc);
        chk("validsalida1", {7'd0, validsalida1}, {7'd0, mon_e.v1}, cyc);
        chk("validsalida2", {7'd0, validsalida2}, {7'd0, mon_e.v2}, cyc);
        chk("validsalida3", {7'd0, validsalida3}, {7'd0, mon_e.v3}, cyc);
      end
    end
  end

  task automatic expect4(input logic [7:0] d0, d1, d2, d3, input logic v0, v1, v2, v3);
    exp_t e;
    e.due = cyc;
    e.d0 = d0; e.d1 = d1; e.d2 = d2; e.d3 = d3;
    e.v0 = v0; e.v1 = v1; e.v2 = v2; e.v3 = v3;
    q.push_back(e);
  endtask

  task automatic expect_zero();
    expect4(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Present one word per lane; it is sampled on the next rising edge.
  task automatic drive(input logic [7:0] a, input logic va, input logic [7:0] b, input logic vb);
    Entrada0 = a; validEntrada0 = va;
    Entrada1 = b; validEntrada1 = vb;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    expect_zero();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    Entrada0 = 8'h00; validEntrada0 = 1'b0;
    Entrada1 = 8'h00; validEntrada1 = 1'b0;
    repeat (3) @(posedge clk_2f);
    #1;
    expect_zero();
    reset = 1'b0;

    // Idle after reset: everything stays zero.
    repeat (4) begin
      drive(8'h00, 1'b0, 8'h00, 1'b0);
      expect_zero();
    end

    // Lane A stream starting in EVEN; outputs change only every second edge.
    rst_pulse();
    drive(8'hA1, 1'b1, 8'h00, 1'b0);
    expect_zero();
    drive(8'hA2, 1'b1, 8'h00, 1'b0);
    expect4(8'hA1, 8'hA2, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(8'hA3, 1'b1, 8'h00, 1'b0);
    expect4(8'hA1, 8'hA2, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(8'hA4, 1'b1, 8'h00, 1'b0);
    expect4(8'hA3, 8'hA4, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    expect4(8'hA3, 8'hA4, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Both lanes together update on the same edge.
    rst_pulse();
    drive(8'h10, 1'b1, 8'h20, 1'b1);
    expect_zero();
    drive(8'h11, 1'b1, 8'h21, 1'b1);
    expect4(8'h10, 8'h11, 8'h20, 8'h21, 1'b1, 1'b1, 1'b1, 1'b1);

    // Lane B invalid odd word: valid drops, data keeps the previous good value.
    rst_pulse();
    drive(8'h00, 1'b0, 8'h30, 1'b1);
    expect_zero();
    drive(8'h00, 1'b0, 8'h31, 1'b1);
    expect4(8'h00, 8'h00, 8'h30, 8'h31, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(8'h00, 1'b0, 8'h55, 1'b1);
    expect4(8'h00, 8'h00, 8'h30, 8'h31, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(8'h00, 1'b0, 8'h99, 1'b0);
    expect4(8'h00, 8'h00, 8'h55, 8'h31, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in ODD after 0xC3 was held: no partial pair, 0xC3 is lost.
    rst_pulse();
    drive(8'hE1, 1'b1, 8'h00, 1'b0);
    expect_zero();
    drive(8'hE2, 1'b1, 8'h00, 1'b0);
    expect4(8'hE1, 8'hE2, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(8'hC3, 1'b1, 8'h00, 1'b0);
    expect4(8'hE1, 8'hE2, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    drive(8'hC4, 1'b1, 8'h00, 1'b0);
    reset = 1'b0;
    expect_zero();
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    expect_zero();
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    expect_zero();

    // First valid word after idle lands in an ODD slot of the free-running phase.
    rst_pulse();
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    expect_zero();
    drive(8'h7E, 1'b1, 8'h00, 1'b0);
`ifdef DEMUX_L1_ALIGN_EN
    expect_zero();
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    expect4(8'h7E, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    expect4(8'h00, 8'h7E, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    expect4(8'h00, 8'h7E, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    drive(8'h00, 1'b0, 8'h00, 1'b0);
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk_2f);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
